// File: rtl/mem_slave_pipe.sv
// Parametrised synchronous memory slave with per-byte parity,
// byte enables, a clearing sweep after reset and pipelined reads.
module mem_slave_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  input  logic                   inj_par_err,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [DATA_W/8-1:0]    rsp_perr,
  output logic                   init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [NB-1:0]     par_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;
  logic [NB-1:0]     wr_par;

  logic              acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_word;
  logic [NB-1:0]     rd_perr;

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] dat_q  [RD_LAT];
  logic [DATA_W-1:0] dat_d  [RD_LAT];
  logic [NB-1:0]     perr_q [RD_LAT];
  logic [NB-1:0]     perr_d [RD_LAT];

  assign req_ready = (state_q == RUN);
  assign init_done = (state_q == RUN);
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & ~req_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = req_addr;
    wr_data = req_wdata;
    wr_be   = '0;
    wr_par  = '0;
    unique case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        wr_be   = '1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        if (acc && req_write) begin
          wr_en = 1'b1;
          wr_be = req_be;
          for (int i = 0; i < NB; i++)
            wr_par[i] = (^req_wdata[8*i +: 8]) ^ inj_par_err;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Parity check happens at array read; the result rides the pipe
  always_comb begin
    rd_word = mem_q[req_addr];
    rd_perr = '0;
    for (int i = 0; i < NB; i++)
      rd_perr[i] = (^rd_word[8*i +: 8]) ^ par_q[req_addr][i];
  end

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = rd_acc;
    dat_d[0]  = rd_acc ? rd_word : '0;
    perr_d[0] = rd_acc ? rd_perr : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      dat_d[i]  = dat_q[i-1];
      perr_d[i] = perr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i]  <= '0;
        perr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i]  <= dat_d[i];
        perr_q[i] <= perr_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
          par_q[wr_addr][i]        <= wr_par[i];
        end
      end
    end
  end

  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_rdata = dat_q[RD_LAT-1];
  assign rsp_perr  = perr_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_slave_pipe.sv
// Bench for mem_slave_pipe: three instances (RD_LAT 1, 2, 4) share
// one request stream; responses are matched against a scoreboard.
module tb_mem_slave_pipe;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic          inj_par_err;

  logic          rdy1, rdy2, rdy4;
  logic          rv1, rv2, rv4;
  logic [DW-1:0] rd1, rd2, rd4;
  logic [NB-1:0] pe1, pe2, pe4;
  logic          id1, id2, id4;

  always #5 clk = ~clk;

  mem_slave_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .inj_par_err(inj_par_err), .rsp_valid(rv1),
    .rsp_rdata(rd1), .rsp_perr(pe1), .init_done(id1));

  mem_slave_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .inj_par_err(inj_par_err), .rsp_valid(rv2),
    .rsp_rdata(rd2), .rsp_perr(pe2), .init_done(id2));

  mem_slave_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy4),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .inj_par_err(inj_par_err), .rsp_valid(rv4),
    .rsp_rdata(rd4), .rsp_perr(pe4), .init_done(id4));

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] be;
    bit            inj;
    logic [DW-1:0] exp_d;
    logic [NB-1:0] exp_p;
  } vec_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic [NB-1:0] p;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v,
                     input logic [DW-1:0] d, input logic [NB-1:0] p);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '{0, '0, '0};
    case (k)
      0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
      1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
      default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
    endcase
    if (v) begin
      if (!have) begin
        chk($sformatf("unexpected_rsp_inst%0d", k), {31'd0, v}, 32'd0);
      end else begin
        chk($sformatf("rsp_cycle_inst%0d", k), cyc, e.cyc);
        chk($sformatf("rsp_data_inst%0d", k), {16'd0, d}, {16'd0, e.d});
        chk($sformatf("rsp_perr_inst%0d", k), {30'd0, p}, {30'd0, e.p});
      end
    end else begin
      chk($sformatf("idle_zero_inst%0d", k), {14'd0, p, d}, 32'd0);
      if (have) begin
        if (e.cyc <= cyc)
          chk($sformatf("missing_rsp_inst%0d", k), cyc, e.cyc);
        else
          case (k)
            0: q0.push_front(e);
            1: q1.push_front(e);
            default: q2.push_front(e);
          endcase
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv1, rd1, pe1);
    mon(1, rv2, rd2, pe2);
    mon(2, rv4, rd4, pe4);
  end

  task automatic issue(input vec_t v);
    req_valid   = 1'b1;
    req_write   = v.wr;
    req_addr    = v.addr;
    req_wdata   = v.wdata;
    req_be      = v.be;
    inj_par_err = v.inj;
    @(posedge clk);
    #1;
    if (!v.wr) begin
      q0.push_back('{cyc + 0, v.exp_d, v.exp_p});
      q1.push_back('{cyc + 1, v.exp_d, v.exp_p});
      q2.push_back('{cyc + 3, v.exp_d, v.exp_p});
    end
    req_valid   = 1'b0;
    req_write   = 1'b0;
    inj_par_err = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [NB-1:0] p);
    vec_t v;
    v = '{1'b0, a, 16'h0, 2'b00, 1'b0, d, p};
    issue(v);
  endtask

  task automatic wait_init(input string name);
    int n;
    bit early;
    n     = 0;
    early = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n < 16 && (rdy2 || id2)) early = 1'b1;
    end while (!id2 && n < 100);
    chk({name, "_edges"}, n, 16);
    chk({name, "_early"}, {31'd0, early}, 32'd0);
    chk({name, "_rdy2"}, {31'd0, rdy2}, 32'd1);
    chk({name, "_done1"}, {31'd0, id1}, 32'd1);
    chk({name, "_done4"}, {31'd0, id4}, 32'd1);
  endtask

  vec_t tbl[26];

  initial begin
    int rcyc;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_be      = '0;
    inj_par_err = 1'b0;

    tbl[0]  = '{1, 4'd0,  16'h1111, 2'b11, 0, 16'h0,    2'b00};
    tbl[1]  = '{1, 4'd1,  16'h2222, 2'b11, 0, 16'h0,    2'b00};
    tbl[2]  = '{1, 4'd2,  16'h3333, 2'b11, 0, 16'h0,    2'b00};
    tbl[3]  = '{1, 4'd3,  16'hA55A, 2'b11, 0, 16'h0,    2'b00};
    tbl[4]  = '{0, 4'd3,  16'h0,    2'b00, 0, 16'hA55A, 2'b00};
    tbl[5]  = '{1, 4'd5,  16'h1234, 2'b11, 0, 16'h0,    2'b00};
    tbl[6]  = '{1, 4'd5,  16'hFFFF, 2'b01, 0, 16'h0,    2'b00};
    tbl[7]  = '{0, 4'd5,  16'h0,    2'b11, 0, 16'h12FF, 2'b00};
    tbl[8]  = '{1, 4'd5,  16'hFFFF, 2'b00, 0, 16'h0,    2'b00};
    tbl[9]  = '{0, 4'd5,  16'h0,    2'b00, 0, 16'h12FF, 2'b00};
    tbl[10] = '{1, 4'd7,  16'h00C3, 2'b11, 1, 16'h0,    2'b00};
    tbl[11] = '{0, 4'd7,  16'h0,    2'b00, 0, 16'h00C3, 2'b11};
    tbl[12] = '{1, 4'd7,  16'h00C3, 2'b11, 0, 16'h0,    2'b00};
    tbl[13] = '{0, 4'd7,  16'h0,    2'b00, 0, 16'h00C3, 2'b00};
    tbl[14] = '{1, 4'd9,  16'hBEEF, 2'b10, 0, 16'h0,    2'b00};
    tbl[15] = '{0, 4'd9,  16'h0,    2'b00, 0, 16'hBE00, 2'b00};
    tbl[16] = '{1, 4'd10, 16'h00FF, 2'b11, 0, 16'h0,    2'b00};
    tbl[17] = '{1, 4'd10, 16'h5577, 2'b01, 1, 16'h0,    2'b00};
    tbl[18] = '{0, 4'd10, 16'h0,    2'b00, 0, 16'h0077, 2'b01};
    tbl[19] = '{1, 4'd15, 16'hCAFE, 2'b11, 0, 16'h0,    2'b00};
    tbl[20] = '{0, 4'd15, 16'h0,    2'b00, 0, 16'hCAFE, 2'b00};
    tbl[21] = '{0, 4'd0,  16'h0,    2'b00, 0, 16'h1111, 2'b00};
    tbl[22] = '{0, 4'd1,  16'h0,    2'b00, 0, 16'h2222, 2'b00};
    tbl[23] = '{0, 4'd2,  16'h0,    2'b00, 0, 16'h3333, 2'b00};
    tbl[24] = '{0, 4'd3,  16'h0,    2'b00, 0, 16'hA55A, 2'b00};
    tbl[25] = '{0, 4'd15, 16'h0,    2'b00, 0, 16'hCAFE, 2'b00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy2}, 32'd0);
    chk("rst_init_done", {31'd0, id2}, 32'd0);
    chk("rst_ready_l4", {31'd0, rdy4}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init("init");

    for (int a = 0; a < 16; a++) rd(a[AW-1:0], 16'h0, 2'b00);

    for (int i = 0; i < 26; i++) issue(tbl[i]);

    rd(4'd3, 16'hA55A, 2'b00);
    rd(4'd5, 16'h12FF, 2'b00);
    reset = 1'b1;
    @(posedge clk);
    #1;
    rcyc = cyc;
    while (q0.size() > 0 && q0[q0.size()-1].cyc >= rcyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size()-1].cyc >= rcyc) void'(q1.pop_back());
    while (q2.size() > 0 && q2[q2.size()-1].cyc >= rcyc) void'(q2.pop_back());
    @(negedge clk);
    chk("midrst_ready", {31'd0, rdy2}, 32'd0);
    chk("midrst_valid_l4", {31'd0, rv4}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init("reinit");

    rd(4'd3,  16'h0, 2'b00);
    rd(4'd5,  16'h0, 2'b00);
    rd(4'd7,  16'h0, 2'b00);
    rd(4'd15, 16'h0, 2'b00);

    repeat (8) @(posedge clk);
    #1;
    chk("drain_l1", q0.size(), 0);
    chk("drain_l2", q1.size(), 0);
    chk("drain_l4", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_slave_pipe.md
# mem_slave_pipe

Parametrised synchronous memory slave that succeeds the fixed 8-bit testbench memory model. It adds configurable data width, depth and read latency, per-byte write enables, per-byte even parity with error injection, and a self-clearing initialisation sweep after reset. It sits behind the memory bus interface as the DUT, with the test program acting as bus master on the same clock.

## Interface
Parameters:
- DATA_W, 8: data width in bits; multiple of 8, range 8–64. NB = DATA_W/8 byte lanes.
- ADDR_W, 8: address width; depth = 2^ADDR_W words, range 2–12.
- RD_LAT, 2: read latency in clocks, range 1–4.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  slave can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  NB  byte enables; write only, ignored on reads.
- inj_par_err  in  1  on an accepted write, store inverted parity for each enabled byte.
- rsp_valid  out  1  read response valid; one-cycle pulse per read.
- rsp_rdata  out  DATA_W  read data.
- rsp_perr  out  NB  per-byte parity mismatch for the returned word.
- init_done  out  1  initialisation sweep complete.

## Operation
- Storage: 2^ADDR_W words of DATA_W data bits plus NB parity bits. Even parity: par[i] = XOR of byte i.
- FSM states: INIT and RUN.
  - reset=1 forces INIT with init counter = 0. No array writes occur while reset is high.
  - In INIT (reset=0), each cycle writes word[cnt] = 0 with all parity bits = 0, then increments cnt.
  - On the cycle writing location 2^ADDR_W−1, the FSM moves to RUN.
  - RUN persists until reset.
- req_ready = (state == RUN). init_done = (state == RUN).
- accept = req_valid & req_ready. At most one request per cycle; no request queueing.
- Accepted write: for each i with req_be[i]=1, byte i ← req_wdata byte i and par[i] ← ^byte ^ inj_par_err. Bytes with req_be[i]=0 are unchanged. Writes produce no response.
- Accepted read: the array is read at the accept edge, returning the full word regardless of req_be. The word plus its parity bits enter an RD_LAT-deep valid/data pipeline.
- rsp_perr[i] = (^rsp_rdata byte i) != stored par[i]. It is computed at array read time and carried through the pipeline.
- When rsp_valid=0, rsp_rdata and rsp_perr are 0.
- Read-after-write: a read accepted on any edge after a write's accept edge returns the new data. Write and read cannot share an edge.
- Addresses cover the full 2^ADDR_W range. There is no out-of-range case; address 2^ADDR_W−1 is a normal location.
- Reset mid-operation:
  - In-flight reads are discarded, and rsp_valid is 0 from the reset edge onward.
  - The FSM returns to INIT and the whole array is re-cleared after reset falls.

## Timing
- Reset values: req_ready=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0.
- Initialisation: reset falls before edge E0. Locations 0..2^ADDR_W−1 are written on edges E0..E(2^ADDR_W−1). req_ready and init_done become 1 after edge E(2^ADDR_W−1).
- Read latency: a read accepted at edge t has its response visible in the cycle after edge t+RD_LAT−1. With RD_LAT=1, the response appears in the cycle immediately after acceptance.
- Throughput: one read per cycle, fully pipelined. Consecutive reads yield consecutive rsp_valid pulses in order.
- No response back-pressure: the master must sample rsp_* whenever rsp_valid=1.
- Write data is visible to a read accepted on the next edge. There is no write latency.

## Test plan
- Init, with DATA_W=16, ADDR_W=4, RD_LAT=2: release reset → init_done and req_ready rise after exactly 16 edges. Reading all 16 addresses → every rsp_rdata=0x0000, rsp_perr=00.
- Write/read: write 0xA55A to addr 3 with be=11, then read addr 3 the next cycle → rsp_valid one cycle after the read accept edge+1, rdata=0xA55A, perr=00.
- Byte enables: addr 5 holds 0x1234; write 0xFFFF with be=01 → read returns 0x12FF. Write with be=00 → read still returns 0x12FF.
- Parity inject: write 0x00C3 to addr 7 with be=11, inj_par_err=1 → read returns rdata=0x00C3, perr=11. A rewrite with inj_par_err=0 → perr=00.
- Pipelined reads: reads to addrs 0,1,2,3 on four consecutive edges → four consecutive rsp_valid cycles with data in issue order, no gaps. Repeat with RD_LAT=1 and RD_LAT=4.
- Reset mid-stream: assert reset while two reads are in flight → no rsp_valid pulse, req_ready=0. After release, the full re-init occurs and previously written addresses read back 0.
